// File: rtl/bs_decoder.sv
// Receive-side USB bit stream decoder: SYNC hunt, PID check/classify, body deserialize, field latch.
// Latency: pkt_valid/pkt_err pulse 2 cycles after the edge sampling the closing eop or offending bit.
// No backpressure: one bit consumed per s_valid cycle, gaps of any length tolerated.
module bs_decoder #(
    parameter logic [7:0] SYNC_PAT = 8'b00000001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_in,
    input  logic        s_valid,
    input  logic        eop,
    output logic [1:0]  pkt_type,
    output logic [71:0] data,
    output logic [18:0] token,
    output logic [7:0]  hshake,
    output logic [4:0]  crc5,
    output logic [15:0] crc16,
    output logic        pkt_valid,
    output logic        pkt_err,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_HUNT,
        S_PID,
        S_BODY,
        S_WAIT_EOP,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [1:0] T_NONE   = 2'b00;
    localparam logic [1:0] T_TOKEN  = 2'b01;
    localparam logic [1:0] T_DATA   = 2'b11;
    localparam logic [1:0] T_HSHAKE = 2'b10;

    localparam logic [6:0] TOKEN_BODY_BITS = 7'd16;
    localparam logic [6:0] DATA_BODY_BITS  = 7'd80;

    state_t      state_q,     state_d;
    logic [7:0]  sync_sr_q,   sync_sr_d;
    logic [87:0] sr_q,        sr_d;
    logic [6:0]  cnt_q,       cnt_d;
    logic [1:0]  kind_q,      kind_d;
    logic [1:0]  pkt_type_q,  pkt_type_d;
    logic [71:0] data_q,      data_d;
    logic [18:0] token_q,     token_d;
    logic [7:0]  hshake_q,    hshake_d;
    logic [4:0]  crc5_q,      crc5_d;
    logic [15:0] crc16_q,     crc16_d;
    logic        pkt_valid_q, pkt_valid_d;
    logic        pkt_err_q,   pkt_err_d;

    logic [7:0]  sync_shift;
    logic [7:0]  pid;
    logic [6:0]  cnt_inc;
    logic [6:0]  body_len;

    // Next-state, bit counting and field latching for the receive FSM.
    always_comb begin
        state_d     = state_q;
        sync_sr_d   = sync_sr_q;
        sr_d        = s_valid ? {sr_q[86:0], s_in} : sr_q;
        cnt_d       = cnt_q;
        kind_d      = kind_q;
        pkt_type_d  = pkt_type_q;
        data_d      = data_q;
        token_d     = token_q;
        hshake_d    = hshake_q;
        crc5_d      = crc5_q;
        crc16_d     = crc16_q;
        pkt_valid_d = 1'b0;
        pkt_err_d   = 1'b0;

        sync_shift = {sync_sr_q[6:0], s_in};
        pid        = sr_d[7:0];
        cnt_inc    = cnt_q + 7'd1;
        body_len   = (kind_q == T_DATA) ? DATA_BODY_BITS : TOKEN_BODY_BITS;

        case (state_q)
            S_HUNT: begin
                // eop is meaningless here; only the SYNC window matters.
                if (s_valid) begin
                    sync_sr_d = sync_shift;
                    if (sync_shift == SYNC_PAT) begin
                        state_d = S_PID;
                        cnt_d   = 7'd0;
                    end
                end
            end

            S_PID: begin
                if (s_valid) begin
                    cnt_d = cnt_inc;
                    if (cnt_q == 7'd7) begin
                        cnt_d = 7'd0;
                        if (pid[7:4] != ~pid[3:0]) begin
                            state_d = S_ERR;
                        end else begin
                            case (pid[1:0])
                                T_TOKEN, T_DATA: begin
                                    kind_d  = pid[1:0];
                                    // A body-carrying packet cannot end on its PID.
                                    state_d = eop ? S_ERR : S_BODY;
                                end
                                T_HSHAKE: begin
                                    kind_d  = T_HSHAKE;
                                    state_d = eop ? S_DONE : S_WAIT_EOP;
                                end
                                default: state_d = S_ERR;
                            endcase
                        end
                    end else if (eop) begin
                        state_d = S_ERR;
                    end
                end else if (eop) begin
                    state_d = S_ERR;
                end
            end

            S_BODY: begin
                // The bit is counted before eop is judged, so a final bit with eop completes.
                if (s_valid) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == body_len) begin
                        state_d = eop ? S_DONE : S_WAIT_EOP;
                    end else if (eop) begin
                        state_d = S_ERR;
                    end
                end else if (eop) begin
                    state_d = S_ERR;
                end
            end

            S_WAIT_EOP: begin
                // Any bit here makes the packet overlength, even alongside eop.
                if (s_valid) begin
                    state_d = S_ERR;
                end else if (eop) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                pkt_valid_d = 1'b1;
                pkt_type_d  = kind_q;
                case (kind_q)
                    T_TOKEN: begin
                        token_d = sr_q[23:5];
                        crc5_d  = sr_q[4:0];
                    end
                    T_DATA: begin
                        data_d  = sr_q[87:16];
                        crc16_d = sr_q[15:0];
                    end
                    default: hshake_d = sr_q[7:0];
                endcase
                state_d   = S_HUNT;
                sync_sr_d = 8'hFF;
            end

            S_ERR: begin
                pkt_err_d = 1'b1;
                state_d   = S_HUNT;
                sync_sr_d = 8'hFF;
            end

            default: begin
                state_d   = S_HUNT;
                sync_sr_d = 8'hFF;
            end
        endcase
    end

    // State, shift registers and registered outputs; synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_HUNT;
            sync_sr_q   <= 8'hFF;
            sr_q        <= '0;
            cnt_q       <= '0;
            kind_q      <= T_NONE;
            pkt_type_q  <= T_NONE;
            data_q      <= '0;
            token_q     <= '0;
            hshake_q    <= '0;
            crc5_q      <= '0;
            crc16_q     <= '0;
            pkt_valid_q <= 1'b0;
            pkt_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_sr_q   <= sync_sr_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            kind_q      <= kind_d;
            pkt_type_q  <= pkt_type_d;
            data_q      <= data_d;
            token_q     <= token_d;
            hshake_q    <= hshake_d;
            crc5_q      <= crc5_d;
            crc16_q     <= crc16_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_err_q   <= pkt_err_d;
        end
    end

    assign pkt_type  = pkt_type_q;
    assign data      = data_q;
    assign token     = token_q;
    assign hshake    = hshake_q;
    assign crc5      = crc5_q;
    assign crc16     = crc16_q;
    assign pkt_valid = pkt_valid_q;
    assign pkt_err   = pkt_err_q;
    assign busy      = (state_q != S_HUNT);

endmodule

// File: tb/tb_bs_decoder.sv
// Directed bench for bs_decoder: handshake/token/data decode, PID and length errors, reset and SYNC hunt.
// Latency: result pulses are sampled on the falling edge two rising edges after the closing stimulus.
// No backpressure: stimulus is driven one bit per cycle on the falling edge.
module tb_bs_decoder;

    logic        clk;
    logic        rst;
    logic        s_in;
    logic        s_valid;
    logic        eop;
    logic [1:0]  pkt_type;
    logic [71:0] data;
    logic [18:0] token;
    logic [7:0]  hshake;
    logic [4:0]  crc5;
    logic [15:0] crc16;
    logic        pkt_valid;
    logic        pkt_err;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    localparam logic [63:0] PAYLOAD  = 64'h0123456789ABCDEF;
    localparam logic [18:0] TOKEN_IN = {8'h69, 7'h05, 4'h1};

    bs_decoder #(.SYNC_PAT(8'b00000001)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_in      (s_in),
        .s_valid   (s_valid),
        .eop       (eop),
        .pkt_type  (pkt_type),
        .data      (data),
        .token     (token),
        .hshake    (hshake),
        .crc5      (crc5),
        .crc16     (crc16),
        .pkt_valid (pkt_valid),
        .pkt_err   (pkt_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [87:0] obs, input logic [87:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic b, input logic e);
        @(negedge clk);
        s_valid = v;
        s_in    = b;
        eop     = e;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_bits(input logic [87:0] v, input int n, input logic eop_last);
        for (int i = n - 1; i >= 0; i--) begin
            drive(1'b1, v[i], eop_last && (i == 0));
        end
    endtask

    task automatic send_sync();
        send_bits(88'h01, 8, 1'b0);
    endtask

    // Called right after the closing stimulus has been set up for the next rising edge.
    task automatic check_result(input string tag, input logic exp_v, input logic exp_e);
        idle();
        @(negedge clk);
        chk({tag, "_valid"}, pkt_valid, exp_v);
        chk({tag, "_err"}, pkt_err, exp_e);
        @(negedge clk);
        chk({tag, "_pulse_end"}, {pkt_valid, pkt_err}, 2'b00);
        chk({tag, "_busy_after"}, busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_in = 1'b0; eop = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pkt_type", pkt_type, 2'b00);
        chk("rst_data", data, 72'h0);
        chk("rst_token", token, 19'h0);
        chk("rst_hshake", hshake, 8'h0);
        chk("rst_crc5", crc5, 5'h0);
        chk("rst_crc16", crc16, 16'h0);
        chk("rst_pulses", {pkt_valid, pkt_err}, 2'b00);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;

        // A lone '1' after reset must not look like SYNC.
        drive(1'b1, 1'b1, 1'b0);
        idle();
        chk("lone_one_busy", busy, 1'b0);

        // Handshake ACK, with an idle gap after SYNC.
        send_sync();
        idle();
        chk("sync_busy", busy, 1'b1);
        send_bits(88'hD2, 8, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        check_result("ack", 1'b1, 1'b0);
        chk("ack_type", pkt_type, 2'b10);
        chk("ack_hshake", hshake, 8'hD2);

        // Token IN.
        send_sync();
        send_bits(88'h69, 8, 1'b0);
        send_bits({7'h05, 4'h1, 5'h0E}, 16, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        check_result("tok", 1'b1, 1'b0);
        chk("tok_type", pkt_type, 2'b01);
        chk("tok_token", token, TOKEN_IN);
        chk("tok_crc5", crc5, 5'h0E);
        chk("tok_hshake_kept", hshake, 8'hD2);

        // DATA0 with eop on the last bit.
        send_sync();
        send_bits(88'hC3, 8, 1'b0);
        send_bits({PAYLOAD, 16'hBEEF}, 80, 1'b1);
        check_result("dat", 1'b1, 1'b0);
        chk("dat_type", pkt_type, 2'b11);
        chk("dat_data", data, {8'hC3, PAYLOAD});
        chk("dat_crc16", crc16, 16'hBEEF);
        chk("dat_token_kept", token, TOKEN_IN);

        // Bad PID: outputs must stay as the DATA packet left them.
        send_sync();
        send_bits(88'hD3, 8, 1'b0);
        check_result("badpid", 1'b0, 1'b1);
        chk("badpid_type", pkt_type, 2'b11);
        chk("badpid_data", data, {8'hC3, PAYLOAD});
        send_sync();
        send_bits(88'hD2, 8, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        check_result("ack2", 1'b1, 1'b0);
        chk("ack2_type", pkt_type, 2'b10);

        // Short token: eop after 10 body bits, then a NAK.
        send_sync();
        send_bits(88'h69, 8, 1'b0);
        send_bits(88'h0A2, 10, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        check_result("short", 1'b0, 1'b1);
        send_sync();
        send_bits(88'h5A, 8, 1'b1);
        check_result("nak", 1'b1, 1'b0);
        chk("nak_hshake", hshake, 8'h5A);

        // Overlength handshake, then an ACK.
        send_sync();
        send_bits(88'hD2, 8, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        check_result("long", 1'b0, 1'b1);
        chk("long_hshake_kept", hshake, 8'h5A);
        send_sync();
        send_bits(88'hD2, 8, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        check_result("ack3", 1'b1, 1'b0);
        chk("ack3_hshake", hshake, 8'hD2);

        // Reset in the middle of a data body.
        send_sync();
        send_bits(88'hC3, 8, 1'b0);
        send_bits(88'h2AAAAAAA, 30, 1'b0);
        @(negedge clk);
        rst = 1'b1; s_valid = 1'b0; s_in = 1'b0; eop = 1'b0;
        @(negedge clk);
        chk("mid_rst_type", pkt_type, 2'b00);
        chk("mid_rst_data", data, 72'h0);
        chk("mid_rst_token", token, 19'h0);
        chk("mid_rst_hshake", hshake, 8'h0);
        chk("mid_rst_crcs", {crc5, crc16}, 21'h0);
        chk("mid_rst_pulses", {pkt_valid, pkt_err}, 2'b00);
        chk("mid_rst_busy", busy, 1'b0);
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0);
        idle();
        chk("post_rst_pulses", {pkt_valid, pkt_err}, 2'b00);
        chk("post_rst_one_busy", busy, 1'b0);

        // Seven zeros then a one right after re-arm is a genuine SYNC.
        send_bits(88'h01, 8, 1'b0);
        idle();
        chk("rearm_sync_busy", busy, 1'b1);
        send_bits(88'hD2, 8, 1'b1);
        check_result("ack4", 1'b1, 1'b0);
        chk("ack4_type", pkt_type, 2'b10);
        chk("ack4_hshake", hshake, 8'hD2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
